// File: rtl/seg_scan_ctrl_if.sv
// Host/display bus for the segment scan controller.
// The slave side is the scan controller; the master side is whoever owns the
// digit registers and the door decoder (the bench, or the surrounding block).
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 4,
  parameter int DIV_W  = 16
);
  logic                  en;
  logic [DIV_W-1:0]      period;
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     blank_mask;
  logic [3:0]            A;
  logic [7:0]            S;
  logic [7:0]            seg_out;
  logic [DIGITS-1:0]     dig_sel;
  logic                  frame_done;
  logic                  busy;

  modport master (
    output en, period, load, data_in, blank_mask, S,
    input  A, seg_out, dig_sel, frame_done, busy
  );

  modport slave (
    input  en, period, load, data_in, blank_mask, S,
    output A, seg_out, dig_sel, frame_done, busy
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed display scanner sharing one external code decoder.
// A frame of 4-bit codes is double-buffered (pend -> shadow) and swapped only
// at frame boundaries, so a displayed frame never mixes old and new digits.
// Each digit gets one blanked SETUP cycle (decoder settles, no ghosting)
// followed by max(period,1) SHOW cycles.

// Per-digit select: this position is lit when it is the scanned index and
// its blank bit is clear.
module seg_scan_lane #(
  parameter int K     = 0,
  parameter int IDX_W = 2
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             blank,
  output logic             sel
);
  assign sel = (idx == IDX_W'(K)) & ~blank;
endmodule

module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV_W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_scan_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(DIGITS);

  typedef enum logic [1:0] {IDLE, SETUP, SHOW} state_t;

  state_t                   state;
  logic [DIGITS-1:0][3:0]   shadow;
  logic [DIGITS-1:0][3:0]   pend;
  logic                     pend_v;
  logic [IDX_W-1:0]         idx;
  logic [DIV_W-1:0]         cnt;

  logic [DIGITS-1:0][3:0]   xfer;
  logic [DIGITS-1:0]        sel_nxt;
  logic [IDX_W-1:0]         idx_inc;
  logic                     last;
  logic [DIV_W-1:0]         dwell;

  // Frame that becomes active at a boundary: the queued one if any.
  assign xfer    = pend_v ? pend : shadow;
  assign idx_inc = idx + IDX_W'(1);
  assign last    = (idx == IDX_W'(DIGITS - 1));
  // period of 0 behaves as 1; counter runs dwell..0 inclusive.
  assign dwell   = (bus.period == '0) ? '0 : bus.period - DIV_W'(1);
  assign bus.busy = (state != IDLE);

  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_lane
      seg_scan_lane #(.K(k), .IDX_W(IDX_W)) u_lane (
        .idx   (idx),
        .blank (bus.blank_mask[k]),
        .sel   (sel_nxt[k])
      );
    end
  endgenerate

  // Scan FSM, frame double-buffer and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      shadow         <= '0;
      pend           <= '0;
      pend_v         <= 1'b0;
      idx            <= '0;
      cnt            <= '0;
      bus.A          <= '0;
      bus.seg_out    <= '0;
      bus.dig_sel    <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      if (!bus.en) begin
        // Abandon any partial frame; queued data is kept.
        state       <= IDLE;
        idx         <= '0;
        cnt         <= '0;
        bus.A       <= '0;
        bus.seg_out <= '0;
        bus.dig_sel <= '0;
      end else begin
        case (state)
          IDLE: begin
            state       <= SETUP;
            idx         <= '0;
            shadow      <= xfer;
            pend_v      <= 1'b0;
            bus.A       <= xfer[0];
            bus.dig_sel <= '0;
          end
          SETUP: begin
            // Decoder output has had a full cycle to settle on A.
            state       <= SHOW;
            bus.seg_out <= bus.S;
            bus.dig_sel <= sel_nxt;
            cnt         <= dwell;
          end
          SHOW: begin
            if (cnt != '0) begin
              cnt <= cnt - DIV_W'(1);
            end else begin
              state       <= SETUP;
              bus.dig_sel <= '0;
              if (last) begin
                idx            <= '0;
                bus.frame_done <= 1'b1;
                shadow         <= xfer;
                pend_v         <= 1'b0;
                bus.A          <= xfer[0];
              end else begin
                idx   <= idx_inc;
                bus.A <= shadow[idx_inc];
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
      // A load in a transfer cycle wins over the clear and waits a frame.
      if (bus.load) begin
        pend   <= bus.data_in;
        pend_v <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus randomized runs, checked
// cycle by cycle against a frame/digit/phase arithmetic model.
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   ncmp = 0;
  int   nfail = 0;
  logic [15:0] base = 16'h0;

  seg_scan_ctrl_if #(.DIGITS(4), .DIV_W(16)) bus ();

  seg_scan_ctrl #(.DIGITS(4), .DIV_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // External door decoder: 7-segment (gfedcba) with dp set on codes >= 8.
  function automatic logic [7:0] dec(input logic [3:0] a);
    logic [6:0] s;
    case (a)
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return {a[3], s};
  endfunction

  assign bus.S = dec(bus.A);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " A"},          32'(bus.A), 32'h0);
    check({tag, " seg_out"},    32'(bus.seg_out), 32'h0);
    check({tag, " dig_sel"},    32'(bus.dig_sel), 32'h0);
    check({tag, " frame_done"}, 32'(bus.frame_done), 32'h0);
    check({tag, " busy"},       32'(bus.busy), 32'h0);
  endtask

  task automatic idle_load(input logic [15:0] d);
    bus.load = 1'b1;
    bus.data_in = d;
    @(posedge clk); #1;
    bus.load = 1'b0;
    base = d;
  endtask

  // Enable for ncyc cycles (en drops in the last one), with up to two loads
  // at cycles c0 < c1. Cycle c is the cycle after the c-th edge that sees en.
  // Frame f starts at edge f*len and shows the newest load sampled before it.
  task automatic run_scan(input int p, input logic [3:0] blk, input int ncyc,
                          input int nld, input int c0, input logic [15:0] d0,
                          input int c1, input logic [15:0] d1);
    int pe, len, f, r, d, s;
    logic [15:0] fr;
    logic [3:0]  code, esel;
    pe  = (p == 0) ? 1 : p;
    len = 4 * (1 + pe);
    bus.period = 16'(p);
    bus.blank_mask = blk;
    bus.en = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      f = c / len; r = c % len; d = r / (1 + pe); s = r % (1 + pe);
      fr = base;
      if (nld > 0 && c0 + 1 < f * len) fr = d0;
      if (nld > 1 && c1 + 1 < f * len) fr = d1;
      code = fr[4*d +: 4];
      esel = (s == 0 || blk[d]) ? 4'b0 : 4'(1 << d);
      check($sformatf("A p=%0d c=%0d", p, c), 32'(bus.A), 32'(code));
      check($sformatf("dig_sel p=%0d c=%0d", p, c), 32'(bus.dig_sel), 32'(esel));
      check($sformatf("frame_done p=%0d c=%0d", p, c), 32'(bus.frame_done),
            32'(c > 0 && r == 0));
      check($sformatf("busy c=%0d", c), 32'(bus.busy), 32'h1);
      check($sformatf("onehot c=%0d", c), 32'($countones(bus.dig_sel) <= 1), 32'h1);
      if (s != 0)
        check($sformatf("seg_out p=%0d c=%0d", p, c), 32'(bus.seg_out), 32'(dec(code)));
      else if (c == 0)
        check("seg_out first setup", 32'(bus.seg_out), 32'h0);
      bus.load = (nld > 0 && c == c0) || (nld > 1 && c == c1);
      bus.data_in = (nld > 1 && c == c1) ? d1 : d0;
      if (c == ncyc - 1) bus.en = 1'b0;
    end
    @(posedge clk); #1;
    bus.load = 1'b0;
    check_idle("after en drop");
    if (nld > 1) base = d1;
    else if (nld > 0) base = d0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int p, n, nl, a0, a1;
    bus.en = 1'b0; bus.period = 16'd0; bus.load = 1'b0;
    bus.data_in = 16'h0; bus.blank_mask = 4'h0;
    #1;
    check_idle("in reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("after reset");

    // Basic scan: 3210, period 3, 16-cycle frames.
    idle_load(16'h3210);
    run_scan(3, 4'b0000, 48, 0, 0, 16'h0, 0, 16'h0);
    // Mid-frame load during digit 1 appears only from the next frame.
    run_scan(3, 4'b0000, 48, 1, 6, 16'h7654, 0, 16'h0);
    // Two loads before one boundary: only the second is shown.
    run_scan(3, 4'b0000, 48, 2, 3, 16'h1111, 9, 16'hABCD);
    // Load in the wrap cycle: earlier pending frame shows, new one a frame later.
    run_scan(3, 4'b0000, 48, 2, 5, 16'h2468, 15, 16'h9BDF);
    // Period 0 with digit 2 blanked: 8-cycle frames.
    run_scan(0, 4'b0100, 24, 0, 0, 16'h0, 0, 16'h0);
    // Enable drop during digit 2 dwell, then restart from digit 0.
    run_scan(3, 4'b0000, 10, 0, 0, 16'h0, 0, 16'h0);
    run_scan(3, 4'b0000, 20, 0, 0, 16'h0, 0, 16'h0);

    // Async reset mid-SHOW clears outputs with no clock edge.
    bus.period = 16'd3; bus.blank_mask = 4'h0; bus.en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre-reset dig_sel", 32'(bus.dig_sel), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async reset");
    bus.en = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    base = 16'h0;
    run_scan(1, 4'b0000, 16, 0, 0, 16'h0, 0, 16'h0);

    // Randomized runs.
    for (int i = 0; i < 6; i++) begin
      p  = $urandom_range(0, 4);
      n  = 4 * (1 + ((p == 0) ? 1 : p));
      n  = n * $urandom_range(2, 3) + $urandom_range(0, n - 1);
      nl = $urandom_range(0, 2);
      a0 = $urandom_range(0, n - 2);
      a1 = $urandom_range(a0 + 1, n - 1);
      run_scan(p, 4'($urandom), n, nl, a0, 16'($urandom), a1, 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller that shares the single combinational `door` code decoder (4-bit code `A` in, 8-bit pattern `S` out) among `DIGITS` display positions. It latches a frame of 4-bit digit codes, presents one code at a time to the decoder, registers the decoded pattern and drives a one-hot digit select for a programmable dwell. It sits between the register or host logic holding the digit values and the display pins, with `door` instantiated beside it.

## Interface
- `DIGITS`, 4: number of multiplexed positions; range 2..8.
- `DIV_W`, 16: width of the dwell counter and `period`.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  scan enable; level.
- `period`  in  DIV_W  dwell in cycles per digit; 0 treated as 1.
- `load`  in  1  request to take a new frame from `data_in`; single-cycle pulse.
- `data_in`  in  4*DIGITS  digit codes; digit k is `data_in[4k+3:4k]`.
- `blank_mask`  in  DIGITS  bit k=1 suppresses digit k; sampled each SETUP.
- `A`  out  4  code to `door` decoder.
- `S`  in  8  decoded pattern from `door`; combinational from `A`.
- `seg_out`  out  8  registered pattern to the display.
- `dig_sel`  out  DIGITS  one-hot, active-high digit enable.
- `frame_done`  out  1  one-cycle pulse after the last digit's dwell.
- `busy`  out  1  high whenever state != IDLE.

## Operation
- Registers:
  - `shadow` (4*DIGITS): the active frame.
  - `pend` (4*DIGITS) with a `pend_v` flag: the queued frame.
  - `idx`: digit index, 0..DIGITS-1.
  - `cnt` (DIV_W): dwell counter.
- Frame capture:
  - `load` copies `data_in` into `pend` and sets `pend_v`. Any earlier pending frame is overwritten, so the last load wins.
  - `pend` transfers to `shadow` only at a frame boundary: on IDLE->SETUP entry and on the SHOW->SETUP transition with idx wrapping to 0.
  - The transfer clears `pend_v`. A `load` in that same cycle re-sets `pend_v` with the new data and is applied at the next boundary.
  - A frame therefore never mixes old and new digits.
- State machine: IDLE, SETUP, SHOW.
  - IDLE:
    - Outputs: `dig_sel`=0, `seg_out`=0, `A`=0, `idx`=0.
    - Moves to SETUP when `en`=1.
  - SETUP (1 cycle):
    - Drives `A`=`shadow[idx]` and forces `dig_sel`=0 (anti-ghost gap).
    - Next state is SHOW.
  - SHOW:
    - On entry, `seg_out`<=`S` and `dig_sel`<=onehot(idx), or 0 if `blank_mask[idx]`.
    - `cnt` loads max(`period`,1)-1 and decrements to 0.
    - At 0: if idx=DIGITS-1, set idx=0 and pulse `frame_done`; otherwise idx+1. Then go to SETUP.
  - `en`=0 in any state: go to IDLE at the next edge and clear outputs. A partial frame is abandoned without `frame_done`.
- `A` holds its value through SHOW, so `S` stays stable.
- `period` is sampled only at SHOW entry. Changing it mid-dwell affects the next digit only.

## Timing
- Reset (async, `rst_n`=0):
  - State IDLE.
  - `A`=0, `seg_out`=0, `dig_sel`=0, `frame_done`=0, `busy`=0.
  - `shadow`=0, `pend_v`=0, `cnt`=0, `idx`=0.
- Reset asserted mid-frame clears all outputs immediately, without waiting for a clock edge.
- Latency:
  - `en` rises at edge e0. SETUP occupies e0..e1 and `A` is valid after e0.
  - `dig_sel` and `seg_out` are valid after e1.
- Per digit: 1 SETUP cycle + P SHOW cycles, where P=max(`period`,1). Frame length is DIGITS*(1+P) cycles.
- `frame_done` is asserted during the cycle the last SHOW ends, coincident with its SETUP transition, and is 1 cycle wide.
- `dig_sel` is never multi-hot. There is always at least one cycle with `dig_sel`=0 between two different digits.

## Test plan
- **Basic scan**: DIGITS=4, `period`=3, load `data_in`=16'h3210, `en`=1.
  - `A` sequence: 0,1,2,3.
  - `dig_sel` sequence: 0001, 0010, 0100, 1000, each high 3 cycles, separated by 1-cycle zero gaps.
  - `seg_out`=`S`(code) during each dwell.
  - `frame_done` every 16 cycles.
- **Frame atomicity**: issue `load` 16'h7654 mid-frame (during digit 1).
  - The remaining digits still show 2,3.
  - The next frame shows 4,5,6,7.
  - Two loads before the boundary: only the second appears.
- **Period 0 and blanking**: `period`=0, `blank_mask`=4'b0100.
  - Each dwell is 1 cycle; frame = 8 cycles.
  - `dig_sel` stays 0 for digit 2 while `A` still steps to that code.
- **Enable drop**: `en`=0 during digit 2 dwell.
  - Next edge: IDLE, all outputs 0, no `frame_done`.
  - Re-enable: scan restarts at digit 0.
- **Async reset**: `rst_n` low mid-SHOW.
  - Outputs clear with no clock edge.
  - After release with `en`=1, scan starts from `shadow`=0 (`A`=0 for all digits) until a `load`.
- **Boundary load collision**: `load` pulsed in the exact wrap cycle.
  - The pending frame transferred at that boundary is displayed.
  - The new data appears one frame later.
  - `pend_v` remains 1 after the wrap.
